// File: rtl/instr_encoder.sv
// instr_encoder: packs RV32I field sets into 32-bit words with addresses and error tracking.
// Ports:
//    clk, rst_n (async active-low), clr (sync clear of pc and err_cnt)
//    in_valid/in_ready   : field-set handshake (OPC, func3, func7, RS1, RS2, RD, imm)
//    out_valid/out_ready : word handshake (instr, addr, err)
//    err_cnt             : saturating count of accepted erroneous words
module instr_encoder #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [6:0]  OPC,
   input  logic [2:0]  func3,
   input  logic [6:0]  func7,
   input  logic [4:0]  RS1,
   input  logic [4:0]  RS2,
   input  logic [4:0]  RD,
   input  logic [31:0] imm,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] instr,
   output logic [31:0] addr,
   output logic        err,
   output logic [7:0]  err_cnt
);
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic [31:0] pc, word, enc;
   logic        bad, acc;

   // Sign-extension checks: the bits above the encodable field must all equal its sign bit.
   logic i_ok, b_ok, j_ok;
   assign i_ok = &imm[31:11] | ~|imm[31:11];
   assign b_ok = (&imm[31:12] | ~|imm[31:12]) & ~imm[0];
   assign j_ok = (&imm[31:20] | ~|imm[31:20]) & ~imm[0];

   always_comb begin
      word = NOP;
      bad  = 1'b1;
      case (OPC)
         7'b0110011: begin
            word = {func7, RS2, RS1, func3, RD, OPC};
            bad  = 1'b0;
         end
         7'b0010011: begin
            word = (func3 == 3'b001 || func3 == 3'b101) ? {func7, imm[4:0], RS1, func3, RD, OPC}
                                                        : {imm[11:0], RS1, func3, RD, OPC};
            bad  = (func3 == 3'b001 || func3 == 3'b101) ? |imm[31:5] : !i_ok;
         end
         7'b0000011, 7'b1100111, 7'b1110011: begin
            word = {imm[11:0], RS1, func3, RD, OPC};
            bad  = !i_ok;
         end
         7'b0100011: begin
            word = {imm[11:5], RS2, RS1, func3, imm[4:0], OPC};
            bad  = !i_ok;
         end
         7'b1100011: begin
            word = {imm[12], imm[10:5], RS2, RS1, func3, imm[4:1], imm[11], OPC};
            bad  = !b_ok;
         end
         7'b0110111, 7'b0010111: begin
            word = {imm[31:12], RD, OPC};
            bad  = |imm[11:0];
         end
         7'b1101111: begin
            word = {imm[20], imm[10:1], imm[11], imm[19:12], RD, OPC};
            bad  = !j_ok;
         end
         default: begin
            word = NOP;
            bad  = 1'b1;
         end
      endcase
      enc = bad ? NOP : word;
   end

   assign in_ready = !out_valid || out_ready;
   assign acc      = in_valid && in_ready;

   // clr overrides the running pc/err_cnt before this cycle's acceptance is applied.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         instr     <= NOP;
         addr      <= BASE_ADDR;
         err       <= 1'b0;
         err_cnt   <= 8'd0;
         pc        <= BASE_ADDR;
      end else begin
         if (acc) begin
            instr <= enc;
            err   <= bad;
            addr  <= clr ? BASE_ADDR : pc;
         end
         out_valid <= acc || (out_valid && !out_ready);
         pc        <= (clr ? BASE_ADDR : pc) + (acc ? 32'd4 : 32'd0);
         err_cnt   <= clr ? {7'd0, acc && bad}
                          : err_cnt + {7'd0, acc && bad && err_cnt != 8'hFF};
      end
   end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed vector bench for instr_encoder with stall, clear, saturation and reset sequences.
module tb_instr_encoder;
   localparam logic [31:0] BASE = 32'hFFFF_FFF0;
   localparam logic [31:0] NOP  = 32'h0000_0013;

   logic        clk = 0, rst_n = 0, clr = 0, in_valid = 0, out_ready = 1;
   logic [6:0]  opc = 0, f7 = 0;
   logic [2:0]  f3 = 0;
   logic [4:0]  rs1 = 0, rs2 = 0, rd = 0;
   logic [31:0] imm = 0;
   logic        in_ready, out_valid, err;
   logic [31:0] instr, addr;
   logic [7:0]  err_cnt;

   int compared = 0, mismatched = 0;

   instr_encoder #(.BASE_ADDR(BASE)) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
      .OPC(opc), .func3(f3), .func7(f7), .RS1(rs1), .RS2(rs2), .RD(rd), .imm(imm),
      .out_valid(out_valid), .out_ready(out_ready), .instr(instr), .addr(addr),
      .err(err), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [6:0]  opc;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [4:0]  rs1, rs2, rd;
      logic [31:0] imm;
      logic [31:0] ins;
      logic        e;
   } vec_t;

   vec_t v[22];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t x);
      in_valid = 1;
      opc = x.opc; f3 = x.f3; f7 = x.f7;
      rs1 = x.rs1; rs2 = x.rs2; rd = x.rd; imm = x.imm;
   endtask

   initial begin
      logic [7:0]  ecnt;
      logic [31:0] held;
      v[0]  = '{7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'd5,         32'h00500093, 1'b0};
      v[1]  = '{7'h33, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 32'd0,         32'h002081B3, 1'b0};
      v[2]  = '{7'h23, 3'd2, 7'h00, 5'd1, 5'd2, 5'd0, 32'd8,         32'h0020A423, 1'b0};
      v[3]  = '{7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC,  32'hFE000EE3, 1'b0};
      v[4]  = '{7'h6F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'd3,         NOP,          1'b1};
      v[5]  = '{7'h13, 3'd1, 7'h00, 5'd6, 5'd0, 5'd5, 32'd3,         32'h00331293, 1'b0};
      v[6]  = '{7'h13, 3'd5, 7'h20, 5'd6, 5'd0, 5'd5, 32'd3,         32'h40335293, 1'b0};
      v[7]  = '{7'h13, 3'd1, 7'h00, 5'd6, 5'd0, 5'd5, 32'd32,        NOP,          1'b1};
      v[8]  = '{7'h37, 3'd0, 7'h00, 5'd3, 5'd0, 5'd7, 32'h12345000,  32'h123453B7, 1'b0};
      v[9]  = '{7'h17, 3'd0, 7'h00, 5'd0, 5'd0, 5'd7, 32'h00001004,  NOP,          1'b1};
      v[10] = '{7'h13, 3'd0, 7'h00, 5'd0, 5'd9, 5'd1, 32'd2047,      32'h7FF00093, 1'b0};
      v[11] = '{7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'd2048,      NOP,          1'b1};
      v[12] = '{7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'hFFFFF800,  32'h80000093, 1'b0};
      v[13] = '{7'h6F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'hFFFFFFF8,  32'hFF9FF0EF, 1'b0};
      v[14] = '{7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd4096,      NOP,          1'b1};
      v[15] = '{7'h00, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd0,         NOP,          1'b1};
      v[16] = '{7'h23, 3'd2, 7'h00, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFF,  32'hFE20AFA3, 1'b0};
      v[17] = '{7'h73, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd0,         32'h00000073, 1'b0};
      v[18] = '{7'h67, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd0,         32'h00008067, 1'b0};
      v[19] = '{7'h03, 3'd2, 7'h00, 5'd2, 5'd0, 5'd5, 32'hFFFFFFFC,  32'hFFC12283, 1'b0};
      v[20] = '{7'h63, 3'd1, 7'h00, 5'd1, 5'd2, 5'd0, 32'd16,        32'h00209863, 1'b0};
      v[21] = '{7'h63, 3'd1, 7'h00, 5'd1, 5'd2, 5'd0, 32'd3,         NOP,          1'b1};

      // reset state
      repeat (2) @(negedge clk);
      chk("rst out_valid", {31'd0, out_valid}, 0);
      chk("rst instr", instr, NOP);
      chk("rst addr", addr, BASE);
      chk("rst err", {31'd0, err}, 0);
      chk("rst err_cnt", {24'd0, err_cnt}, 0);
      chk("rst in_ready", {31'd0, in_ready}, 1);
      rst_n = 1;

      // table: back-to-back flow, addresses wrap past 2^32
      ecnt = 0;
      for (int i = 0; i <= 22; i++) begin
         @(negedge clk);
         if (i > 0) begin
            if (v[i-1].e) ecnt++;
            chk($sformatf("vec%0d out_valid", i-1), {31'd0, out_valid}, 1);
            chk($sformatf("vec%0d instr", i-1), instr, v[i-1].ins);
            chk($sformatf("vec%0d err", i-1), {31'd0, err}, {31'd0, v[i-1].e});
            chk($sformatf("vec%0d addr", i-1), addr, BASE + 32'(4 * (i-1)));
            chk($sformatf("vec%0d err_cnt", i-1), {24'd0, err_cnt}, {24'd0, ecnt});
         end
         if (i < 22) begin
            drive(v[i]);
            chk($sformatf("vec%0d in_ready", i), {31'd0, in_ready}, 1);
         end else in_valid = 0;
      end
      @(negedge clk);
      chk("drain out_valid", {31'd0, out_valid}, 0);

      // stall: first word held, clr during hold, second accepted when out_ready rises
      out_ready = 0;
      drive(v[0]);
      @(negedge clk);
      held = addr;
      chk("stall A instr", instr, 32'h00500093);
      chk("stall A addr", addr, BASE + 32'(4 * 22));
      drive(v[1]);
      #1 chk("stall in_ready", {31'd0, in_ready}, 0);
      clr = 1;
      @(negedge clk);
      clr = 0;
      chk("clr err_cnt", {24'd0, err_cnt}, 0);
      chk("clr held valid", {31'd0, out_valid}, 1);
      @(negedge clk);
      chk("hold instr", instr, 32'h00500093);
      chk("hold addr", addr, held);
      chk("hold err", {31'd0, err}, 0);
      out_ready = 1;
      #1 chk("release in_ready", {31'd0, in_ready}, 1);
      @(negedge clk);
      chk("stall B instr", instr, 32'h002081B3);
      chk("stall B addr", addr, BASE);
      in_valid = 0;
      @(negedge clk);
      chk("stall drain", {31'd0, out_valid}, 0);

      // saturation of err_cnt over 256 illegal words
      drive(v[15]);
      repeat (255) @(negedge clk);
      chk("sat 255", {24'd0, err_cnt}, 255);
      @(negedge clk);
      chk("sat hold 255", {24'd0, err_cnt}, 255);
      drive(v[0]);
      clr = 1;
      @(negedge clk);
      chk("clr+acc err_cnt", {24'd0, err_cnt}, 0);
      chk("clr+acc addr", addr, BASE);
      chk("clr+acc instr", instr, 32'h00500093);
      drive(v[15]);
      @(negedge clk);
      chk("clr+bad err_cnt", {24'd0, err_cnt}, 1);
      chk("clr+bad addr", addr, BASE);
      clr = 0;
      drive(v[1]);
      @(negedge clk);
      chk("post clr addr", addr, BASE + 32'd4);
      chk("post clr err_cnt", {24'd0, err_cnt}, 1);

      // async reset while a word is held
      out_ready = 0;
      in_valid = 0;
      @(negedge clk);
      #2 rst_n = 0;
      #1;
      chk("async out_valid", {31'd0, out_valid}, 0);
      chk("async instr", instr, NOP);
      chk("async err_cnt", {24'd0, err_cnt}, 0);
      chk("async in_ready", {31'd0, in_ready}, 1);
      @(negedge clk);
      rst_n = 1;
      out_ready = 1;
      drive(v[0]);
      @(negedge clk);
      in_valid = 0;
      chk("after rst addr", addr, BASE);
      chk("after rst instr", instr, 32'h00500093);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
